// File: rtl/vedic_pkg.sv
// Shared definitions for the sequential Vedic 16x16 multiplier: controller states,
// the default half-operand width and the partial-product alignment shifts.
package vedic_pkg;

   localparam int VEDIC_HALF_W = 8;

   localparam int SH_0   = 0;
   localparam int SH_MID = VEDIC_HALF_W;
   localparam int SH_HI  = 2 * VEDIC_HALF_W;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PP_LL = 3'd1,
      PP_HL = 3'd2,
      PP_LH = 3'd3,
      PP_HH = 3'd4,
      DONE  = 3'd5
   } state_e;

endpackage

// File: rtl/mul8x8_pp.sv
// Combinational HALF_W x HALF_W unsigned partial-product multiplier, built as a
// Vedic (Urdhva-Tiryagbhyam) tree of 2x2 cells when HALF_W is 8.
module mul8x8_pp #(
   parameter int HALF_W = 8
) (
   input  logic [HALF_W-1:0]   op_a_i,
   input  logic [HALF_W-1:0]   op_b_i,
   output logic [2*HALF_W-1:0] pp_o
);

   function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
      logic s1, c1, s2, c2;
      s1 = (x[1] & y[0]) ^ (x[0] & y[1]);
      c1 = (x[1] & y[0]) & (x[0] & y[1]);
      s2 = (x[1] & y[1]) ^ c1;
      c2 = (x[1] & y[1]) & c1;
      return {c2, s2, s1, x[0] & y[0]};
   endfunction

   function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
      logic [7:0] q0, q1, q2, q3;
      q0 = {4'b0, vedic2(x[1:0], y[1:0])};
      q1 = {4'b0, vedic2(x[3:2], y[1:0])};
      q2 = {4'b0, vedic2(x[1:0], y[3:2])};
      q3 = {4'b0, vedic2(x[3:2], y[3:2])};
      return q0 + (q1 << 2) + (q2 << 2) + (q3 << 4);
   endfunction

   function automatic logic [15:0] vedic8(input logic [7:0] x, input logic [7:0] y);
      logic [15:0] q0, q1, q2, q3;
      q0 = {8'b0, vedic4(x[3:0], y[3:0])};
      q1 = {8'b0, vedic4(x[7:4], y[3:0])};
      q2 = {8'b0, vedic4(x[3:0], y[7:4])};
      q3 = {8'b0, vedic4(x[7:4], y[7:4])};
      return q0 + (q1 << 4) + (q2 << 4) + (q3 << 8);
   endfunction

   // Non-default widths fall back to a plain multiplier rather than a Vedic tree.
   generate
      if (HALF_W == 8) begin : g_vedic
         assign pp_o = vedic8(op_a_i, op_b_i);
      end else begin : g_generic
         assign pp_o = {{HALF_W{1'b0}}, op_a_i} * {{HALF_W{1'b0}}, op_b_i};
      end
   endgenerate

endmodule

// File: rtl/vedic_mul16_seq_ctrl.sv
// Sequential 16x16 unsigned multiplier: one shared 8x8 Vedic partial-product
// multiplier and a 2W-bit accumulator, four partial products over four cycles.
module vedic_mul16_seq_ctrl
   import vedic_pkg::*;
#(
   parameter int HALF_W = VEDIC_HALF_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2*HALF_W-1:0]   a,
   input  logic [2*HALF_W-1:0]   b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*HALF_W-1:0]   product
);

   localparam int W = 2 * HALF_W;

   state_e              state_q, state_d;
   logic [W-1:0]        a_q, a_d;
   logic [W-1:0]        b_q, b_d;
   logic [2*W-1:0]      acc_q, acc_d;

   logic [HALF_W-1:0]   sel_a, sel_b;
   logic [W-1:0]        pp;
   logic [2*W-1:0]      pp_ext;
   logic [2*W-1:0]      addend;

   mul8x8_pp #(
      .HALF_W (HALF_W)
   ) u_pp (
      .op_a_i (sel_a),
      .op_b_i (sel_b),
      .pp_o   (pp)
   );

   assign pp_ext = {{W{1'b0}}, pp};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
      end
   end

   // The accumulator never wraps: each running sum is bounded by (2^W-1)^2.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      sel_a   = a_q[HALF_W-1:0];
      sel_b   = b_q[HALF_W-1:0];
      addend  = '0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               acc_d   = '0;
               state_d = PP_LL;
            end
         end
         PP_LL: begin
            addend  = pp_ext << SH_0;
            acc_d   = acc_q + addend;
            state_d = PP_HL;
         end
         PP_HL: begin
            sel_a   = a_q[W-1:HALF_W];
            addend  = pp_ext << SH_MID;
            acc_d   = acc_q + addend;
            state_d = PP_LH;
         end
         PP_LH: begin
            sel_b   = b_q[W-1:HALF_W];
            addend  = pp_ext << SH_MID;
            acc_d   = acc_q + addend;
            state_d = PP_HH;
         end
         PP_HH: begin
            sel_a   = a_q[W-1:HALF_W];
            sel_b   = b_q[W-1:HALF_W];
            addend  = pp_ext << SH_HI;
            acc_d   = acc_q + addend;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign product   = acc_q;

endmodule

// File: tb/tb_vedic_mul16_seq_ctrl.sv
// Directed bench for vedic_mul16_seq_ctrl: latency, handshakes, backpressure,
// asynchronous reset mid-operation and back-to-back transfers.
module tb_vedic_mul16_seq_ctrl;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] product;

   int vectors;
   int miscompares;

   vedic_mul16_seq_ctrl #(
      .HALF_W (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Entered and left at a falling edge with the DUT idle. keep_valid leaves
   // in_valid high after acceptance and presents na/nb as the next operands.
   task automatic xact(input string tag, input logic [15:0] va, input logic [15:0] vb,
                       input logic [31:0] exp, input int stall, input bit keep_valid,
                       input logic [15:0] na, input logic [15:0] nb);
      chk({tag, "_rdy_pre"}, {31'b0, in_ready}, 32'd1);
      chk({tag, "_vld_pre"}, {31'b0, out_valid}, 32'd0);
      a        = va;
      b        = vb;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = keep_valid;
      a        = na;
      b        = nb;
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_busy_rdy"}, {31'b0, in_ready}, 32'd0);
         chk({tag, "_busy_vld"}, {31'b0, out_valid}, 32'd0);
         @(negedge clk);
      end
      chk({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
      chk({tag, "_prod"}, product, exp);
      chk({tag, "_rdy_done"}, {31'b0, in_ready}, 32'd0);
      if (stall > 0) begin
         out_ready = 1'b0;
         for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            a        = 16'h1111 * 16'(s + 1);
            b        = 16'h2222;
            @(negedge clk);
            chk({tag, "_hold_vld"}, {31'b0, out_valid}, 32'd1);
            chk({tag, "_hold_prod"}, product, exp);
            chk({tag, "_hold_rdy"}, {31'b0, in_ready}, 32'd0);
         end
         out_ready = 1'b1;
         in_valid  = 1'b0;
      end
      @(negedge clk);
      chk({tag, "_vld_post"}, {31'b0, out_valid}, 32'd0);
      chk({tag, "_rdy_post"}, {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b1;
      out_ready   = 1'b1;
      a           = 16'hDEAD;
      b           = 16'hBEEF;

      repeat (3) @(negedge clk);
      chk("rst_rdy", {31'b0, in_ready}, 32'd1);
      chk("rst_vld", {31'b0, out_valid}, 32'd0);
      chk("rst_prod", product, 32'h0);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_rdy", {31'b0, in_ready}, 32'd1);
      chk("idle_vld", {31'b0, out_valid}, 32'd0);
      chk("idle_prod", product, 32'h0);

      xact("x1234", 16'h1234, 16'h5678, 32'h0626_0060, 0, 1'b0, 16'h0, 16'h0);
      xact("xffff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0, 1'b0, 16'h0, 16'h0);
      xact("x8000", 16'h8000, 16'h0002, 32'h0001_0000, 0, 1'b0, 16'h0, 16'h0);
      xact("xzero", 16'h0000, 16'hABCD, 32'h0000_0000, 0, 1'b0, 16'h0, 16'h0);
      xact("xff00", 16'hFF00, 16'hFF00, 32'hFE01_0000, 0, 1'b0, 16'h0, 16'h0);
      xact("xbp",   16'h00FF, 16'h0100, 32'h0000_FF00, 3, 1'b0, 16'h0, 16'h0);

      // Reset asserted while the third partial product is being accumulated.
      a        = 16'h1234;
      b        = 16'h5678;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_vld", {31'b0, out_valid}, 32'd0);
      chk("mid_rst_prod", product, 32'h0);
      chk("mid_rst_rdy", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_vld", {31'b0, out_valid}, 32'd0);
         chk("post_rst_prod", product, 32'h0);
      end

      xact("b2b0", 16'h0003, 16'h0005, 32'h0000_000F, 0, 1'b1, 16'h0100, 16'h0100);
      xact("b2b1", 16'h0100, 16'h0100, 32'h0001_0000, 0, 1'b1, 16'hFFFF, 16'h0001);
      xact("b2b2", 16'hFFFF, 16'h0001, 32'h0000_FFFF, 0, 1'b0, 16'h0, 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vedic_mul16_seq_ctrl.md
Name: vedic_mul16_seq_ctrl

Overview:
- Sequential 16x16 unsigned multiplier controller.
- Time-shares one 8x8 partial-product multiplier and a 2W-bit shift/accumulate adder across four cycles, instead of the fully parallel four-multiplier Vedic structure.
- Sits between an operand source and a result consumer, with valid/ready handshakes on both sides.
- Gives an area-reduced alternative to the combinational 16-bit Vedic multiplier.

Parameters:
- HALF_W, 8: half-operand width. Operand width W = 2*HALF_W; product width = 2*W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a/b are valid.
- in_ready  output  1  controller can accept operands.
- a  input  W  multiplicand, unsigned.
- b  input  W  multiplier, unsigned.
- out_valid  output  1  product is valid.
- out_ready  input  1  consumer accepts product.
- product  output  2W  unsigned result a*b.

Behaviour:
- Clocking and reset: one clock domain (clk). rst_n is asynchronous assert, synchronous deassert, active-low.
- Reset values:
  - state=IDLE
  - in_ready=1
  - out_valid=0
  - product/acc=0
  - latched operands=0
- FSM states: IDLE, PP_LL, PP_HL, PP_LH, PP_HH, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b into a_q, b_q; clear acc; go to PP_LL.
- PP_LL: acc <= acc + (a_q[L]*b_q[L]); go to PP_HL.
- PP_HL: acc <= acc + ((a_q[H]*b_q[L]) << HALF_W); go to PP_LH.
- PP_LH: acc <= acc + ((a_q[L]*b_q[H]) << HALF_W); go to PP_HH.
- PP_HH: acc <= acc + ((a_q[H]*b_q[H]) << W); go to DONE.
- DONE:
  - out_valid=1; product=acc, held stable.
  - On out_ready: go to IDLE. out_valid drops the next cycle.
- Handshakes and hold:
  - in_ready=1 only in IDLE. in_ready and out_valid are never high in the same cycle.
  - Operand inputs are ignored outside IDLE.
  - out_valid stays high, and product stays stable, until out_ready is sampled high.
- Latency: handshake accepted in cycle N → out_valid high in cycle N+5. With out_ready tied high, the minimum initiation interval is 6 cycles.
- Partial-product mux: one shared 8x8 multiplier. Its operand selects are driven combinationally from state (L = [HALF_W-1:0], H = [W-1:HALF_W]). Outside the PP_* states the selects are don't-care, and acc is not updated.
- Widths and overflow:
  - acc is 2W bits; all additions are zero-extended to 2W.
  - The final sum never overflows 2W bits.
  - No intermediate wrap occurs, because the running partial sum is always ≤ (2^W−1)^2.
- Reset mid-operation: an asynchronous return to IDLE with the reset values. The in-flight result is discarded and no out_valid pulse is produced.
- in_valid held high while busy: the next operands are accepted only after returning to IDLE. Nothing is lost if the source holds valid per protocol.

Decomposition:
- Shared package vedic_pkg:
  - state enum/localparams (IDLE=0 … DONE=5, 3 bits)
  - HALF_W default
  - shift constants SH_0=0, SH_MID=HALF_W, SH_HI=2*HALF_W
- Sub-module mul8x8_pp: combinational HALF_W x HALF_W unsigned Vedic multiplier producing a 2*HALF_W product. It is instantiated once.
- Controller: FSM, operand latch, select mux, accumulator adder.

Test Plan:
- Reset with in_valid=1, then release rst_n → in_ready=1, out_valid=0, product=0 until the first accepted transaction.
- a=0x1234, b=0x5678, accepted at cycle N, out_ready=1 → out_valid rises at N+5 with product=0x06260060, a 1-cycle pulse; in_ready back at N+6.
- a=0xFFFF, b=0xFFFF → product=0xFFFE0001. Separately, a=0x8000, b=0x0002 → 0x00010000. Also a=0x0000, b=0xABCD → 0x00000000.
- Backpressure: a=0x00FF, b=0x0100, out_ready low 3 cycles after out_valid → out_valid and product (0x0000FF00) held, in_ready=0, new in_valid/a/b changes ignored. The transfer completes on the out_ready high cycle.
- Reset mid-operation: assert rst_n=0 in PP_LH → out_valid, acc and product are 0 immediately (asynchronous). After release, the FSM is in IDLE and no stale result appears.
- Back-to-back: 3 transactions with in_valid held high and out_ready=1 → results in order at 6-cycle spacing, each matching the reference model a*b.
